// File: rtl/lc3b_wb_stage.sv
// Writeback buffer behind the LC-3b ALU: a 2-entry FIFO of ALU results with
// their NZP codes, an architectural CC register updated at pop, and a
// combinational read-after-write forwarding lookup over buffered entries.
module lc3b_wb_stage #(
    parameter int WIDTH = 16,
    parameter int RADDR = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [RADDR-1:0] in_dest,
    input  logic             in_ld_reg,
    input  logic             in_ld_cc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [RADDR-1:0] out_dest,
    output logic             out_we,
    output logic [2:0]       cc_q,
    input  logic [RADDR-1:0] chk_reg,
    output logic             chk_hit,
    output logic [WIDTH-1:0] chk_data
);

    // Entry storage; never reset, occupancy is tracked by count alone.
    logic [WIDTH-1:0] result_mem [2];
    logic [RADDR-1:0] dest_mem   [2];
    logic             ld_reg_mem [2];
    logic             ld_cc_mem  [2];
    logic [2:0]       nzp_mem    [2];

    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;
    logic       young;

    // Exactly one of n/z/p is set for any value.
    function automatic logic [2:0] calc_nzp(input logic [WIDTH-1:0] value);
        logic n;
        logic z;
        n = value[WIDTH-1];
        z = (value == '0);
        return {n, z, ~n & ~z};
    endfunction

    assign in_ready   = (count != 2'd2);
    assign out_valid  = (count != 2'd0);
    assign push       = in_valid & in_ready;
    assign pop        = out_valid & out_ready;
    assign out_result = result_mem[rd_ptr];
    assign out_dest   = dest_mem[rd_ptr];
    assign out_we     = pop & ld_reg_mem[rd_ptr];
    // The most recently pushed entry sits just behind the write pointer.
    assign young      = ~wr_ptr;

    // Control state: pointers, occupancy and the architectural CC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            cc_q   <= 3'b010;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                if (ld_cc_mem[rd_ptr]) begin
                    cc_q <= nzp_mem[rd_ptr];
                end
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Capture the pushed entry and its condition code into the write slot.
    always_ff @(posedge clk) begin
        if (push) begin
            result_mem[wr_ptr] <= in_result;
            dest_mem[wr_ptr]   <= in_dest;
            ld_reg_mem[wr_ptr] <= in_ld_reg;
            ld_cc_mem[wr_ptr]  <= in_ld_cc;
            nzp_mem[wr_ptr]    <= calc_nzp(in_result);
        end
    end

    // Forwarding lookup: check the older entry first so the younger one overrides.
    always_comb begin
        chk_hit  = 1'b0;
        chk_data = '0;
        if ((count == 2'd2) && ld_reg_mem[rd_ptr] && (dest_mem[rd_ptr] == chk_reg)) begin
            chk_hit  = 1'b1;
            chk_data = result_mem[rd_ptr];
        end
        if ((count != 2'd0) && ld_reg_mem[young] && (dest_mem[young] == chk_reg)) begin
            chk_hit  = 1'b1;
            chk_data = result_mem[young];
        end
    end

endmodule
